// File: rtl/layer4_argmax.sv
`default_nettype none
// ============================================================================
// Module   : layer4_argmax
// Purpose  : Snapshot a vector of 8-bit node outputs, scan it one element per
//            cycle and report argmax class, max value and margin to runner-up.
// Revision : 1.0
// ============================================================================
module layer4_argmax #(
    parameter int N_IN  = 24,
    parameter int IDX_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8*N_IN-1:0]   in_vec,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    output logic [IDX_W-1:0]    out_class,
    output logic [7:0]          out_max,
    output logic [7:0]          out_margin,
    output logic [15:0]         out_count,
    output logic                err_drop
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_IN - 1);

    state_t                   state_q, state_d;
    logic [N_IN-1:0][7:0]     snap_q, snap_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [7:0]               best_val_q, best_val_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic [7:0]               second_val_q, second_val_d;
    logic                     out_valid_q, out_valid_d;
    logic [IDX_W-1:0]         out_class_q, out_class_d;
    logic [7:0]               out_max_q, out_max_d;
    logic [7:0]               out_margin_q, out_margin_d;
    logic [15:0]              out_count_q, out_count_d;
    logic                     err_drop_q, err_drop_d;

    logic [7:0]               w_elem;
    logic [7:0]               w_best_val;
    logic [IDX_W-1:0]         w_best_idx;
    logic [7:0]               w_second_val;

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        idx_d        = idx_q;
        best_val_d   = best_val_q;
        best_idx_d   = best_idx_q;
        second_val_d = second_val_q;
        out_valid_d  = 1'b0;
        out_class_d  = out_class_q;
        out_max_d    = out_max_q;
        out_margin_d = out_margin_q;
        out_count_d  = out_count_q;
        err_drop_d   = err_drop_q;

        // Strict compares: an equal later element only ever becomes runner-up,
        // so the lowest index wins ties and the margin collapses to 0.
        w_elem       = snap_q[idx_q];
        w_best_val   = best_val_q;
        w_best_idx   = best_idx_q;
        w_second_val = second_val_q;
        if (w_elem > best_val_q) begin
            w_second_val = best_val_q;
            w_best_val   = w_elem;
            w_best_idx   = idx_q;
        end else if (w_elem > second_val_q) begin
            w_second_val = w_elem;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    snap_d       = in_vec;
                    idx_d        = '0;
                    best_val_d   = '0;
                    best_idx_d   = '0;
                    second_val_d = '0;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                best_val_d   = w_best_val;
                best_idx_d   = w_best_idx;
                second_val_d = w_second_val;
                idx_d        = idx_q + 1'b1;
                if (in_valid) begin
                    err_drop_d = 1'b1;
                end
                // Results come from the post-update values so the final
                // element participates in the reported answer.
                if (idx_q == c_LAST_IDX) begin
                    out_class_d  = w_best_idx;
                    out_max_d    = w_best_val;
                    out_margin_d = w_best_val - w_second_val;
                    out_valid_d  = 1'b1;
                    out_count_d  = out_count_q + 16'd1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            idx_q        <= '0;
            best_val_q   <= '0;
            best_idx_q   <= '0;
            second_val_q <= '0;
            out_valid_q  <= 1'b0;
            out_class_q  <= '0;
            out_max_q    <= '0;
            out_margin_q <= '0;
            out_count_q  <= '0;
            err_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
            best_val_q   <= best_val_d;
            best_idx_q   <= best_idx_d;
            second_val_q <= second_val_d;
            out_valid_q  <= out_valid_d;
            out_class_q  <= out_class_d;
            out_max_q    <= out_max_d;
            out_margin_q <= out_margin_d;
            out_count_q  <= out_count_d;
            err_drop_q   <= err_drop_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_class  = out_class_q;
    assign out_max    = out_max_q;
    assign out_margin = out_margin_q;
    assign out_count  = out_count_q;
    assign err_drop   = err_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_layer4_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer4_argmax
// Purpose  : Self-checking bench for layer4_argmax with a result scoreboard.
// Revision : 1.0
// ============================================================================
module tb_layer4_argmax;

    localparam int N_IN  = 24;
    localparam int IDX_W = 5;
    localparam int VW    = 8 * N_IN;

    logic              clk = 1'b0;
    logic              reset;
    logic [VW-1:0]     in_vec;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic [IDX_W-1:0]  out_class;
    logic [7:0]        out_max;
    logic [7:0]        out_margin;
    logic [15:0]       out_count;
    logic              err_drop;

    layer4_argmax #(.N_IN(N_IN), .IDX_W(IDX_W)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_vec     (in_vec),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_class  (out_class),
        .out_max    (out_max),
        .out_margin (out_margin),
        .out_count  (out_count),
        .err_drop   (err_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] vec;
        int            cls;
        int            mx;
        int            mg;
    } vec_t;

    typedef struct {
        int cls;
        int mx;
        int mg;
        int acc;
    } exp_t;

    vec_t  tbl [5];
    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_mis = 0;
    int    cyc = 0;
    int    exp_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int i, input logic [7:0] x);
        logic [VW-1:0] r;
        r = v;
        r[i*8 +: 8] = x;
        return r;
    endfunction

    // Reference: first index holding the maximum, runner-up is the largest of the rest.
    task automatic model(input logic [VW-1:0] v, output int c, output int m, output int g);
        int s;
        c = 0;
        m = int'(v[7:0]);
        for (int i = 1; i < N_IN; i++)
            if (int'(v[i*8 +: 8]) > m) begin
                m = int'(v[i*8 +: 8]);
                c = i;
            end
        s = 0;
        for (int i = 0; i < N_IN; i++)
            if (i != c && int'(v[i*8 +: 8]) > s) s = int'(v[i*8 +: 8]);
        g = m - s;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_out_valid: got 1, expected 0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                exp_count++;
                chk("out_class",  32'(out_class),  32'(e.cls));
                chk("out_max",    32'(out_max),    32'(e.mx));
                chk("out_margin", 32'(out_margin), 32'(e.mg));
                chk("out_count",  32'(out_count),  32'(exp_count & 16'hFFFF));
                chk("latency_cycle", 32'(cyc), 32'(e.acc + N_IN));
            end
        end
    end

    task automatic send(input logic [VW-1:0] v, input int c, input int m, input int g,
                        input bit chk_b2b);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_mis++;
            $display("FAIL send_timeout: in_ready got 0, expected 1");
        end else begin
            if (chk_b2b) chk("b2b_offer_in_out_valid_cycle", 32'(out_valid), 32'd1);
            e.cls = c;
            e.mx  = m;
            e.mg  = g;
            e.acc = cyc + 1;
            sb.push_back(e);
            in_vec   = v;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_rand(input int hi);
        logic [VW-1:0] v;
        int c, m, g;
        v = '0;
        for (int i = 0; i < N_IN; i++) v = put(v, i, 8'($urandom_range(0, hi)));
        model(v, c, m, g);
        send(v, c, m, g, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain_timeout: pending got %0d, expected 0", sb.size());
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
        chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
        chk({tag, "_out_class"},  32'(out_class),  32'd0);
        chk({tag, "_out_max"},    32'(out_max),    32'd0);
        chk({tag, "_out_margin"}, 32'(out_margin), 32'd0);
        chk({tag, "_out_count"},  32'(out_count),  32'd0);
        chk({tag, "_err_drop"},   32'(err_drop),   32'd0);
    endtask

    initial begin
        logic [VW-1:0] v;

        v = '0;
        for (int i = 0; i < N_IN; i++) v = put(v, i, 8'd10);
        v = put(v, 7, 8'd100);
        v = put(v, 3, 8'd90);
        tbl[0] = '{vec: v, cls: 7, mx: 100, mg: 10};
        v = '0;
        v = put(v, 5, 8'd127);
        v = put(v, 12, 8'd127);
        tbl[1] = '{vec: v, cls: 5, mx: 127, mg: 0};
        tbl[2] = '{vec: '0, cls: 0, mx: 0, mg: 0};
        v = '0;
        for (int i = 0; i < N_IN; i++) v = put(v, i, 8'(i * 5));
        v = put(v, 0, 8'd126);
        v = put(v, 23, 8'd127);
        tbl[3] = '{vec: v, cls: 23, mx: 127, mg: 1};
        v = '0;
        v = put(v, 0, 8'd50);
        tbl[4] = '{vec: v, cls: 0, mx: 50, mg: 50};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_vec   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_reset_state("reset");
        repeat (50) @(negedge clk);
        chk("idle_out_count", 32'(out_count), 32'd0);

        for (int k = 0; k < 4; k++)
            send(tbl[k].vec, tbl[k].cls, tbl[k].mx, tbl[k].mg, 1'b0);

        // Offered while the previous result strobes, then a stray mid-scan push.
        send(tbl[4].vec, tbl[4].cls, tbl[4].mx, tbl[4].mg, 1'b1);
        repeat (5) @(negedge clk);
        chk("err_drop_before_pulse", 32'(err_drop), 32'd0);
        in_vec   = '1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("err_drop_after_pulse", 32'(err_drop), 32'd1);
        drain();
        chk("err_drop_sticky", 32'(err_drop), 32'd1);

        for (int k = 0; k < 4; k++) send_rand(255);
        for (int k = 0; k < 3; k++) send_rand(7);
        drain();

        send(tbl[0].vec, tbl[0].cls, tbl[0].mx, tbl[0].mg, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        exp_count = 0;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state("midscan_reset");
        repeat (40) @(negedge clk);
        chk("post_reset_out_count", 32'(out_count), 32'd0);

        send(tbl[3].vec, tbl[3].cls, tbl[3].mx, tbl[3].mg, 1'b0);
        drain();
        chk("final_out_count", 32'(out_count), 32'd1);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
